seq_normalizer: RTL and testbench



---
 rtl/seq_normalizer.sv | 157 +++++++++++++++
 tb/tb_seq_normalizer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_normalizer.sv
// -----------------------------------------------------------------------------
// seq_normalizer
//
// Iterative left-shift normalizer for the FloatMul datapath. It accepts one
// unnormalized mantissa at a time, shifts it left until its MSB is 1, and
// returns the normalized mantissa together with the number of positions it was
// shifted. The exponent logic subtracts that count. An all-zero mantissa is
// flagged through out_zero and is not shifted.
//
// Parameters:
//   W   mantissa width in bits (>= 5)
//   CW  shift-count width; 2**CW must exceed W-1
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   input operand valid
//   in_ready   block idle and able to accept an operand
//   in_data    unnormalized mantissa (W bits)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   normalized mantissa (W bits)
//   out_shift  number of left shifts applied (CW bits)
//   out_zero   input was all zeros
//
// Optional feature (macro SEQ_NORM_SHIFT4_EN):
//   When defined, a SHIFT step moves 4 positions at once whenever the top four
//   bits of the working register are all zero, and 1 position otherwise. The
//   results are identical to the default build; only the latency is shorter.
// -----------------------------------------------------------------------------
module seq_normalizer #(
  parameter int W  = 24,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_shift,
  output logic          out_zero
);

  // Reject parameter sets that cannot work: the 4-bit step slices the top
  // nibble, and the counter must hold a shift of up to W-1.
  generate
    if (W < 5) begin : g_bad_width
      $error("seq_normalizer: W must be >= 5");
    end
    if ((64'd1 << CW) <= 64'(W - 1)) begin : g_bad_count_width
      $error("seq_normalizer: CW too narrow to hold W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_data;       // working register being normalized
  logic [CW-1:0] r_count;      // shifts applied so far
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [CW-1:0] r_out_shift;
  logic          r_out_zero;

  logic          w_msb;
  logic [W-1:0]  w_next_data;
  logic [CW-1:0] w_next_count;

  assign w_msb = r_data[W-1];

`ifdef SEQ_NORM_SHIFT4_EN
  // A zero top nibble guarantees at least four leading zeros, so a 4-bit step
  // can never overshoot the leading one.
  logic w_step4;
  assign w_step4      = (r_data[W-1 -: 4] == 4'b0000);
  assign w_next_data  = w_step4 ? {r_data[W-5:0], 4'b0000} : {r_data[W-2:0], 1'b0};
  assign w_next_count = r_count + (w_step4 ? CW'(4) : CW'(1));
`else
  assign w_next_data  = {r_data[W-2:0], 1'b0};
  assign w_next_count = r_count + CW'(1);
`endif

  // NOTE: every register below is updated with non-blocking assignments so all
  // state moves together at the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_shift <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in_data == '0) begin
              // Nothing to normalize: report zero straight away.
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_shift <= '0;
              r_out_zero  <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_data  <= in_data;
              r_count <= '0;
              r_state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (w_msb) begin
            // Terminating edge: the register is already normalized.
            r_out_valid <= 1'b1;
            r_out_data  <= r_data;
            r_out_shift <= r_count;
            r_out_zero  <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_data  <= w_next_data;
            r_count <= w_next_count;
          end
        end

        DONE: begin
          // Result registers hold until the consumer takes them; returning to
          // IDLE here means a new operand is taken one cycle later at earliest.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_shift = r_out_shift;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_seq_normalizer.sv
// -----------------------------------------------------------------------------
// tb_seq_normalizer
//
// Directed bench for seq_normalizer. Expected results are pushed to a
// scoreboard queue when an operand is accepted and popped when the result is
// handed off. Outputs are sampled on the falling clock edge or 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_normalizer;

  localparam int W  = 24;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_shift;
  logic          out_zero;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] shift;
    logic          zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_normalizer #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge to out_valid for a nonzero input with L
  // leading zeros.
  function automatic int nz_latency(input int l);
`ifdef SEQ_NORM_SHIFT4_EN
    return (l / 4) + (l % 4) + 1;
`else
    return l + 1;
`endif
  endfunction

  // Present one operand and record its expected result at the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] ed,
                      input logic [CW-1:0] es, input logic ez);
    @(negedge clk);
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    sb_q.push_back('{data: ed, shift: es, zero: ez});
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen.
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  // Hold out_ready low for 'hold' cycles (optionally pulsing in_valid at cycle
  // 'pulse_at'), then hand off and compare against the scoreboard.
  task automatic take(input string tag, input int hold, input int pulse_at,
                      input bit keep_ready);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    if (hold > 0) out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"},    32'(out_valid), 32'd1);
      check({tag, "_hold_data"},     32'(out_data),  32'(e.data));
      check({tag, "_hold_shift"},    32'(out_shift), 32'(e.shift));
      check({tag, "_hold_in_ready"}, 32'(in_ready),  32'd0);
      if (i == pulse_at) begin
        in_valid = 1'b1;
        in_data  = 24'h7FFFFF;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(e.data));
    check({tag, "_shift"}, 32'(out_shift), 32'(e.shift));
    check({tag, "_zero"},  32'(out_zero),  32'(e.zero));
    @(posedge clk);
    #1;
    if (!keep_ready) out_ready = 1'b0;
    check({tag, "_valid_after"},    32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Already normalized: one terminating edge.
    send(24'h800000, 24'h800000, 5'd0, 1'b0);
    wait_result("lat_800000", nz_latency(0));
    take("r_800000", 0, -1, 1'b0);

    // Maximum shift.
    send(24'h000001, 24'h800000, 5'd23, 1'b0);
    wait_result("lat_000001", nz_latency(23));
    take("r_000001", 0, -1, 1'b0);

    // Zero input: valid directly after the accepting edge.
    send(24'h000000, 24'h000000, 5'd0, 1'b1);
    wait_result("lat_zero", 0);
    take("r_zero", 0, -1, 1'b0);

    // Backpressure with an ignored in_valid pulse while the result waits.
    send(24'h0034A1, 24'hD28400, 5'd10, 1'b0);
    wait_result("lat_0034a1", nz_latency(10));
    take("r_0034a1", 5, 2, 1'b0);
    check("no_phantom_accept", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check("idle_after_pulse_valid",    32'(out_valid), 32'd0);
    check("idle_after_pulse_in_ready", 32'(in_ready),  32'd1);

    // Reset in the middle of SHIFT aborts the operation.
    send(24'h000100, 24'h800000, 5'd15, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_shift_in_ready", 32'(in_ready),  32'd0);
    check("mid_shift_valid",    32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data",  32'(out_data),  32'd0);
    check("abort_out_shift", 32'(out_shift), 32'd0);
    check("abort_out_zero",  32'(out_zero),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);

    send(24'h400000, 24'h800000, 5'd1, 1'b0);
    wait_result("lat_400000", nz_latency(1));
    take("r_400000", 0, -1, 1'b0);

    // Back-to-back operands with out_ready tied high.
    out_ready = 1'b1;
    send(24'h010000, 24'h800000, 5'd7, 1'b0);
    send_second_after_first();
    out_ready = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic send_second_after_first();
    wait_result("lat_010000", nz_latency(7));
    take("r_010000", 0, -1, 1'b1);
    send(24'h000800, 24'h800000, 5'd12, 1'b0);
    wait_result("lat_000800", nz_latency(12));
    take("r_000800", 0, -1, 1'b1);
  endtask

endmodule
